// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the pipelined MIPS core. Tracks in-flight register writes
//   across DEPTH post-decode stages (stage 1 = EX ... stage DEPTH = WB). It
//   forwards results into the ID->EX operand path and raises stall for
//   use-before-ready hazards, such as load-use or long-latency multiply.
//
//   Optional feature macro: HAZ_STATS_EN adds a saturating 32-bit stall
//   counter output (stall_cnt).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   adv               global pipeline advance (0 = whole pipeline frozen)
//   id_valid          instruction present in ID
//   id_a_reg/_used    source A register / instruction reads A
//   id_b_reg/_used    source B register / instruction reads B
//   id_wr_en/_reg     instruction writes back / destination register
//   id_ready_stg      first stage whose output holds the result
//   rf_a, rf_b        register file read data
//   stg_data          result of stage k in bits [k*DATA_W-1 -: DATA_W]
//   a_out, b_out      resolved operands to A_EX/B_EX
//   a_sel, b_sel      0 = register file, k = forwarded from stage k
//   stall             hold PC and ID, insert a bubble into EX
//   stall_cnt         (HAZ_STATS_EN only) count of cycles with stall && adv
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    input  logic                    id_valid,
    input  logic [REG_W-1:0]        id_a_reg,
    input  logic                    id_a_used,
    input  logic [REG_W-1:0]        id_b_reg,
    input  logic                    id_b_used,
    input  logic                    id_wr_en,
    input  logic [REG_W-1:0]        id_wr_reg,
    input  logic [SEL_W-1:0]        id_ready_stg,
    input  logic [DATA_W-1:0]       rf_a,
    input  logic [DATA_W-1:0]       rf_b,
    input  logic [DEPTH*DATA_W-1:0] stg_data,
    output logic [DATA_W-1:0]       a_out,
    output logic [DATA_W-1:0]       b_out,
    output logic [SEL_W-1:0]        a_sel,
    output logic [SEL_W-1:0]        b_sel,
    output logic                    stall
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] dst;
        logic [SEL_W-1:0] rdy;
    } entry_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              haz;
        logic [DATA_W-1:0] data;
    } resolve_t;

    // ent[k] describes the instruction currently in stage k.
    entry_t ent [1:DEPTH];

    logic [SEL_W-1:0] rdy_in;
    resolve_t         res_a;
    resolve_t         res_b;

    // Scan from oldest to youngest so the lowest matching stage wins.
    function automatic resolve_t resolve(input logic [REG_W-1:0]  src,
                                         input logic              used,
                                         input logic [DATA_W-1:0] rf);
        resolve_t r;
        r.sel  = '0;
        r.haz  = 1'b0;
        r.data = rf;
        if (used && src != '0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (ent[k].vld && ent[k].dst == src) begin
                    if (ent[k].rdy <= SEL_W'(k)) begin
                        r.sel  = SEL_W'(k);
                        r.haz  = 1'b0;
                        r.data = stg_data[k*DATA_W-1 -: DATA_W];
                    end else begin
                        r.sel  = '0;
                        r.haz  = 1'b1;
                        r.data = rf;
                    end
                end
            end
        end
        return r;
    endfunction

    // Ready stage 0 means "ALU result"; anything past WB is clamped to WB.
    always_comb begin
        rdy_in = id_ready_stg;
        if (id_ready_stg == '0)
            rdy_in = SEL_W'(1);
        else if (int'(id_ready_stg) > DEPTH)
            rdy_in = SEL_W'(DEPTH);
    end

    always_comb begin
        res_a = resolve(id_a_reg, id_a_used, rf_a);
        res_b = resolve(id_b_reg, id_b_used, rf_b);
        a_sel = res_a.sel;
        a_out = res_a.data;
        b_sel = res_b.sel;
        b_out = res_b.data;
        stall = id_valid && (res_a.haz || res_b.haz);
    end

    // NOTE: sequential state uses non-blocking assignments so that the shift
    // reads the pre-edge value of ent[k-1], not the value just written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++)
                ent[k] <= '0;
        end else if (adv) begin
            ent[1] <= '{vld: id_valid && id_wr_en && !stall,
                        dst: id_wr_reg,
                        rdy: rdy_in};
            for (int k = 2; k <= DEPTH; k++)
                ent[k] <= ent[k-1];
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && adv && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Self-checking bench for hazard_scoreboard. The reference model keeps a
//   queue of in-flight instructions, where queue position i is stage i+1. It
//   then resolves each source by searching for the youngest producer. Directed
//   sequences cover the key scenarios, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 3;
    localparam int SEL_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    adv;
    logic                    id_valid;
    logic [REG_W-1:0]        id_a_reg;
    logic                    id_a_used;
    logic [REG_W-1:0]        id_b_reg;
    logic                    id_b_used;
    logic                    id_wr_en;
    logic [REG_W-1:0]        id_wr_reg;
    logic [SEL_W-1:0]        id_ready_stg;
    logic [DATA_W-1:0]       rf_a;
    logic [DATA_W-1:0]       rf_b;
    logic [DEPTH*DATA_W-1:0] stg_data;
    logic [DATA_W-1:0]       a_out;
    logic [DATA_W-1:0]       b_out;
    logic [SEL_W-1:0]        a_sel;
    logic [SEL_W-1:0]        b_sel;
    logic                    stall;
`ifdef HAZ_STATS_EN
    logic [31:0]             stall_cnt;
`endif

    hazard_scoreboard #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .adv         (adv),
        .id_valid    (id_valid),
        .id_a_reg    (id_a_reg),
        .id_a_used   (id_a_used),
        .id_b_reg    (id_b_reg),
        .id_b_used   (id_b_used),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_ready_stg(id_ready_stg),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .stg_data    (stg_data),
        .a_out       (a_out),
        .b_out       (b_out),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .stall       (stall)
`ifdef HAZ_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit vld;
        int dst;
        int rdy;
    } inflight_t;

    inflight_t pipe[$];
    longint    cnt_model;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        inflight_t e;
        e.vld = 1'b0;
        e.dst = 0;
        e.rdy = 1;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++)
            pipe.push_back(e);
        cnt_model = 0;
    endfunction

    function automatic int clamp_rdy(input int x);
        if (x == 0)
            return 1;
        if (x > DEPTH)
            return DEPTH;
        return x;
    endfunction

    // Find the youngest in-flight producer of r. It forwards if it has
    // already reached its ready stage; otherwise it is a hazard.
    function automatic void model_eval(input int r, input bit used,
                                       output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (!used || r == 0)
            return;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].vld && pipe[i].dst == r) begin
                if (pipe[i].rdy <= i + 1)
                    sel = i + 1;
                else
                    haz = 1'b1;
                return;
            end
        end
    endfunction

    function automatic logic [DATA_W-1:0] stage_value(input int k);
        return DATA_W'(stg_data >> ((k - 1) * DATA_W));
    endfunction

    // One pipeline cycle: drive at negedge, check combinational outputs,
    // then advance the model at the posedge the DUT samples.
    task automatic cycle(input bit v, input int a, input bit au, input int b, input bit bu,
                         input bit we, input int wr, input int rdy, input bit adv_v,
                         output bit exp_stall);
        int  sa, sb;
        bit  ha, hb;
        inflight_t e;
        @(negedge clk);
        adv          = adv_v;
        id_valid     = v;
        id_a_reg     = REG_W'(a);
        id_a_used    = au;
        id_b_reg     = REG_W'(b);
        id_b_used    = bu;
        id_wr_en     = we;
        id_wr_reg    = REG_W'(wr);
        id_ready_stg = SEL_W'(rdy);
        rf_a         = $urandom;
        rf_b         = $urandom;
        stg_data     = {$urandom, $urandom, $urandom};
        #1;
        model_eval(a, au, sa, ha);
        model_eval(b, bu, sb, hb);
        exp_stall = v && (ha || hb);
        check("stall", 64'(stall), 64'(exp_stall));
        check("a_sel", 64'(a_sel), 64'(sa));
        check("b_sel", 64'(b_sel), 64'(sb));
        check("a_out", 64'(a_out), 64'((sa == 0) ? rf_a : stage_value(sa)));
        check("b_out", 64'(b_out), 64'((sb == 0) ? rf_b : stage_value(sb)));
`ifdef HAZ_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(cnt_model));
`endif
        @(posedge clk);
        if (adv_v) begin
            e.vld = v && we && !exp_stall;
            e.dst = wr;
            e.rdy = clamp_rdy(rdy);
            void'(pipe.pop_back());
            pipe.push_front(e);
            if (exp_stall)
                cnt_model++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        adv          = 1'b1;
        id_valid     = 1'b0;
        id_a_reg     = '0;
        id_a_used    = 1'b0;
        id_b_reg     = '0;
        id_b_used    = 1'b0;
        id_wr_en     = 1'b0;
        id_wr_reg    = '0;
        id_ready_stg = '0;
        rf_a         = 32'hA5A5_0001;
        rf_b         = 32'h5A5A_0002;
        stg_data     = {32'h3, 32'h2, 32'h1};
        model_clear();
        @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_a_sel", 64'(a_sel), 64'(0));
        check("rst_a_out", 64'(a_out), 64'(32'hA5A5_0001));
`ifdef HAZ_STATS_EN
        check("rst_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    bit s;

    initial begin
        rst = 1'b0;
        do_reset();

        // ALU RAW: forward from EX with no stall.
        cycle(1, 0, 0, 0, 0, 1, 3, 1, 1, s);
        @(negedge clk);
        id_valid = 1'b1; id_a_reg = 5'd3; id_a_used = 1'b1; id_b_used = 1'b0;
        id_wr_en = 1'b0; stg_data = {32'h0, 32'h0, 32'h1234};
        #1;
        check("raw_stall", 64'(stall), 64'(0));
        check("raw_a_sel", 64'(a_sel), 64'(1));
        check("raw_a_out", 64'(a_out), 64'(32'h1234));
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, s);

        // Load-use: one stall, then forward from MEM.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 5, 2, 1, s);
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        check("lu_stall1", 64'(s), 64'(1));
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        check("lu_stall2", 64'(s), 64'(0));
        check("lu_b_sel", 64'(b_sel), 64'(2));

        // Register 0 never matches.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 0, 2, 1, s);
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 1, s);
        check("r0_a_sel", 64'(a_sel), 64'(0));
        check("r0_stall", 64'(stall), 64'(0));

        // Youngest wins: r7 in stage 3 and stage 1.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 7, 1, 1, s);
        cycle(1, 0, 0, 0, 0, 1, 1, 1, 1, s);
        cycle(1, 0, 0, 0, 0, 1, 7, 1, 1, s);
        cycle(1, 7, 1, 0, 0, 0, 0, 0, 1, s);
        check("yw_a_sel", 64'(a_sel), 64'(1));

        // Freeze during a load-use hazard, then resume.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 5, 2, 1, s);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 5, 1, 0, 0, 0, 0, s);
            check("frz_stall", 64'(stall), 64'(1));
        end
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        check("frz_stall_adv", 64'(stall), 64'(1));
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        check("frz_b_sel", 64'(b_sel), 64'(2));

        // Reset asserted in the middle of a stall.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 5, 2, 1, s);
        @(negedge clk);
        id_valid = 1'b1; id_b_reg = 5'd5; id_b_used = 1'b1; id_a_used = 1'b0;
        id_wr_en = 1'b0;
        #1;
        check("mid_stall_pre", 64'(stall), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_stall", 64'(stall), 64'(0));
        check("mid_a_sel", 64'(a_sel), 64'(0));
        check("mid_b_sel", 64'(b_sel), 64'(0));
        check("mid_b_out", 64'(b_out), 64'(rf_b));
`ifdef HAZ_STATS_EN
        check("mid_cnt", 64'(stall_cnt), 64'(0));
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b1;

        // Three stalled cycles: one load-use stall and two for a ready-at-WB producer.
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 5, 2, 1, s);
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        cycle(1, 0, 0, 5, 1, 0, 0, 0, 1, s);
        cycle(1, 0, 0, 0, 0, 1, 6, 3, 1, s);
        cycle(1, 6, 1, 0, 0, 0, 0, 0, 1, s);
        cycle(1, 6, 1, 0, 0, 0, 0, 0, 1, s);
        cycle(1, 6, 1, 0, 0, 0, 0, 0, 1, s);
        check("wb_a_sel", 64'(a_sel), 64'(3));
`ifdef HAZ_STATS_EN
        @(negedge clk);
        #1;
        check("cnt3", 64'(stall_cnt), 64'(3));
`endif

        // Randomized traffic on a small register set to provoke collisions.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 4) != 0, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
